desnorm_exp_share_arbiter: RTL and testbench

- Shares one fixed-to-float + exponential (deslinealizador) chain between two requesters: channel I (current) and channel V (voltage).
- Round-robin grant, operand mux, one-cycle Begin pulse to the chain, wait for the chain's ACK, capture result into a per-channel register, per-channel ACK pulse.
- Watchdog aborts a hung conversion.
- Sits between the channel front-ends and the single shared denormaliser/delinealiser instance; replaces the duplicated V path.

---
 rtl/desnorm_pkg.sv | 23 ++
 rtl/desnorm_exp_share_arbiter_if.sv | 47 ++++
 rtl/desnorm_exp_share_arbiter_rr_arb2.sv | 35 +++
 rtl/desnorm_exp_share_arbiter.sv | 116 +++++++++++
 tb/tb_desnorm_exp_share_arbiter.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/desnorm_pkg.sv
// Shared definitions for the exponential-chain sharing arbiter.
// - state_e : arbiter FSM state encoding
// - ch_e    : requester channel ids (I = current, V = voltage)
// - DEF_W / DEF_TIMEOUT : default operand width and watchdog limit
package desnorm_pkg;

  localparam int DEF_W       = 32;
  localparam int DEF_TIMEOUT = 255;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_DONE   = 3'd3,
    ST_ABORT  = 3'd4
  } state_e;

  typedef enum logic {
    CH_I = 1'b0,
    CH_V = 1'b1
  } ch_e;

endpackage

// File: rtl/desnorm_exp_share_arbiter_if.sv
// Bus bundle between the two channel front-ends, the arbiter and the shared
// fixed-to-float + exponential chain.
//   channel side : req_i/data_i, req_v/data_v in; ack_i/ack_v, result_i/result_v,
//                  err_to, busy out
//   chain side   : dp_begin, dp_operand, dp_rst out; dp_ack, dp_result in
//   debug        : dbg_state (arbiter FSM state)
// Handshake: a requester raises req_x (level) with data_x stable and holds it
// until it sees a one-cycle ack_x, then drops req_x on the following edge.
// Toward the chain, dp_begin is a one-cycle start pulse with dp_operand valid;
// the chain answers with a one-cycle dp_ack carrying dp_result. An ack_x that
// coincides with err_to means the conversion was aborted and result_x is stale.
interface desnorm_exp_share_arbiter_if import desnorm_pkg::*; #(
  parameter int W = DEF_W
) ();

  logic         req_i;
  logic [W-1:0] data_i;
  logic         req_v;
  logic [W-1:0] data_v;
  logic         ack_i;
  logic         ack_v;
  logic [W-1:0] result_i;
  logic [W-1:0] result_v;
  logic         err_to;
  logic         busy;
  logic         dp_begin;
  logic [W-1:0] dp_operand;
  logic         dp_rst;
  logic         dp_ack;
  logic [W-1:0] dp_result;
  state_e       dbg_state;

  // Arbiter view.
  modport slave (
    input  req_i, data_i, req_v, data_v, dp_ack, dp_result,
    output ack_i, ack_v, result_i, result_v, err_to, busy,
           dp_begin, dp_operand, dp_rst, dbg_state
  );

  // Environment view (front-ends plus chain).
  modport master (
    output req_i, data_i, req_v, data_v, dp_ack, dp_result,
    input  ack_i, ack_v, result_i, result_v, err_to, busy,
           dp_begin, dp_operand, dp_rst, dbg_state
  );

endinterface

// File: rtl/desnorm_exp_share_arbiter_rr_arb2.sv
// Two-input round-robin arbiter.
//   req[0] = channel I, req[1] = channel V
//   grant  : one-hot, combinational from req and last_grant
//   update_en : commit the current grant into last_grant
// last_grant resets to V so that I wins the first tie.
module rr_arb2 import desnorm_pkg::*; (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update_en,
  output logic [1:0] grant
);

  ch_e last_grant;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // Tie goes to the channel that was not served last.
      2'b11:   grant = (last_grant == CH_V) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= CH_V;
    end else if (update_en && (grant != 2'b00)) begin
      last_grant <= grant[1] ? CH_V : CH_I;
    end
  end

endmodule

// File: rtl/desnorm_exp_share_arbiter.sv
// Shares one fixed-to-float + exponential chain between channel I (current)
// and channel V (voltage). Round-robin grant, operand latch at grant, one-cycle
// Begin to the chain, wait for the chain ACK with a watchdog, capture the
// result per channel and pulse the per-channel ACK.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : desnorm_exp_share_arbiter_if.slave (channel + chain signals)
// Parameters:
//   W       : operand/result width
//   TIMEOUT : watchdog limit in WAIT (>= 2)
module desnorm_exp_share_arbiter import desnorm_pkg::*; #(
  parameter int W       = DEF_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                          clk,
  input  logic                          rst,
  desnorm_exp_share_arbiter_if.slave    bus
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  state_e          state;
  ch_e             granted;
  logic [W-1:0]    operand_q;
  logic [W-1:0]    result_i_q;
  logic [W-1:0]    result_v_q;
  logic            begin_q;
  logic            ack_i_q;
  logic            ack_v_q;
  logic            err_to_q;
  logic [WD_W-1:0] wd;
  logic [1:0]      grant;

  // Requests are only looked at while idle, so the arbiter history only
  // advances on a real grant.
  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       ({bus.req_v, bus.req_i}),
    .update_en (state == ST_IDLE),
    .grant     (grant)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      granted    <= CH_I;
      operand_q  <= '0;
      result_i_q <= '0;
      result_v_q <= '0;
      begin_q    <= 1'b0;
      ack_i_q    <= 1'b0;
      ack_v_q    <= 1'b0;
      err_to_q   <= 1'b0;
      wd         <= '0;
    end else begin
      // Pulse outputs default low; each state raises what it needs.
      begin_q  <= 1'b0;
      ack_i_q  <= 1'b0;
      ack_v_q  <= 1'b0;
      err_to_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant != 2'b00) begin
            granted   <= grant[1] ? CH_V : CH_I;
            operand_q <= grant[1] ? bus.data_v : bus.data_i;
            begin_q   <= 1'b1;
            state     <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          wd    <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // A chain ACK in the expiry cycle still counts as a normal finish.
          if (bus.dp_ack) begin
            if (granted == CH_I) begin
              result_i_q <= bus.dp_result;
              ack_i_q    <= 1'b1;
            end else begin
              result_v_q <= bus.dp_result;
              ack_v_q    <= 1'b1;
            end
            state <= ST_DONE;
          end else if (wd == WD_W'(TIMEOUT)) begin
            // wd runs 0..TIMEOUT, so the ACK of an abort lands TIMEOUT+2
            // cycles after the Begin pulse.
            ack_i_q  <= (granted == CH_I);
            ack_v_q  <= (granted == CH_V);
            err_to_q <= 1'b1;
            state    <= ST_ABORT;
          end else begin
            wd <= wd + WD_W'(1);
          end
        end
        ST_DONE:  state <= ST_IDLE;
        ST_ABORT: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign bus.dp_begin   = begin_q;
  assign bus.dp_operand = operand_q;
  // err_to_q is high exactly during ABORT, which doubles as the chain flush.
  assign bus.dp_rst     = rst | err_to_q;
  assign bus.ack_i      = ack_i_q;
  assign bus.ack_v      = ack_v_q;
  assign bus.err_to     = err_to_q;
  assign bus.result_i   = result_i_q;
  assign bus.result_v   = result_v_q;
  assign bus.busy       = (state != ST_IDLE);
  assign bus.dbg_state  = state;

endmodule

// File: tb/tb_desnorm_exp_share_arbiter.sv
module tb_desnorm_exp_share_arbiter;
  import desnorm_pkg::*;

  localparam int W   = 32;
  localparam int TO0 = 255;
  localparam int TO1 = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  desnorm_exp_share_arbiter_if #(.W(W)) bus0 ();
  desnorm_exp_share_arbiter_if #(.W(W)) bus1 ();

  desnorm_exp_share_arbiter #(.W(W), .TIMEOUT(TO0)) dut0 (
    .clk (clk), .rst (rst), .bus (bus0.slave));
  desnorm_exp_share_arbiter #(.W(W), .TIMEOUT(TO1)) dut1 (
    .clk (clk), .rst (rst), .bus (bus1.slave));

  logic         req_i_d[2], req_v_d[2], dp_ack_d[2];
  logic [W-1:0] data_i_d[2], data_v_d[2], dp_res_d[2];
  logic         o_begin[2], o_ack_i[2], o_ack_v[2], o_err[2], o_busy[2], o_dprst[2];
  logic [W-1:0] o_op[2], o_res_i[2], o_res_v[2];

  assign bus0.req_i = req_i_d[0];   assign bus1.req_i = req_i_d[1];
  assign bus0.req_v = req_v_d[0];   assign bus1.req_v = req_v_d[1];
  assign bus0.data_i = data_i_d[0]; assign bus1.data_i = data_i_d[1];
  assign bus0.data_v = data_v_d[0]; assign bus1.data_v = data_v_d[1];
  assign bus0.dp_ack = dp_ack_d[0]; assign bus1.dp_ack = dp_ack_d[1];
  assign bus0.dp_result = dp_res_d[0]; assign bus1.dp_result = dp_res_d[1];

  assign o_begin[0] = bus0.dp_begin;   assign o_begin[1] = bus1.dp_begin;
  assign o_ack_i[0] = bus0.ack_i;      assign o_ack_i[1] = bus1.ack_i;
  assign o_ack_v[0] = bus0.ack_v;      assign o_ack_v[1] = bus1.ack_v;
  assign o_err[0]   = bus0.err_to;     assign o_err[1]   = bus1.err_to;
  assign o_busy[0]  = bus0.busy;       assign o_busy[1]  = bus1.busy;
  assign o_dprst[0] = bus0.dp_rst;     assign o_dprst[1] = bus1.dp_rst;
  assign o_op[0]    = bus0.dp_operand; assign o_op[1]    = bus1.dp_operand;
  assign o_res_i[0] = bus0.result_i;   assign o_res_i[1] = bus1.result_i;
  assign o_res_v[0] = bus0.result_v;   assign o_res_v[1] = bus1.result_v;

  // ---------------- scoreboard bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks each arbiter as "idle" or "serving one request", counting cycles
  // since the Begin pulse. The finishing edge is either the first chain ACK
  // seen after Begin, or the edge that closes the (TIMEOUT+1)-th cycle after
  // Begin with no ACK, which puts the aborting ACK TIMEOUT+2 cycles after Begin.
  int           m_act[2], m_k[2], m_fin[2];
  logic         m_last[2], m_gr[2];
  logic         e_begin[2], e_ack_i[2], e_ack_v[2], e_err[2];
  logic [W-1:0] e_op[2], e_res_i[2], e_res_v[2];

  function automatic int to_of(input int i);
    return (i == 0) ? TO0 : TO1;
  endfunction

  task automatic model_step(input int i);
    if (rst) begin
      m_act[i] = 0; m_k[i] = 0; m_fin[i] = 0; m_last[i] = 1'b1; m_gr[i] = 1'b0;
      e_begin[i] = 0; e_ack_i[i] = 0; e_ack_v[i] = 0; e_err[i] = 0;
      e_op[i] = '0; e_res_i[i] = '0; e_res_v[i] = '0;
    end else begin
      e_begin[i] = 0; e_ack_i[i] = 0; e_ack_v[i] = 0; e_err[i] = 0;
      if (m_fin[i] != 0) begin
        m_fin[i] = 0;
        m_act[i] = 0;
      end else if (m_act[i] == 0) begin
        if (req_i_d[i] || req_v_d[i]) begin
          m_gr[i]   = (req_i_d[i] && req_v_d[i]) ? ~m_last[i] : req_v_d[i];
          m_last[i] = m_gr[i];
          e_op[i]   = m_gr[i] ? data_v_d[i] : data_i_d[i];
          m_act[i]  = 1; m_k[i] = 0; e_begin[i] = 1;
        end
      end else if (m_k[i] >= 1 && dp_ack_d[i]) begin
        if (m_gr[i]) begin e_res_v[i] = dp_res_d[i]; e_ack_v[i] = 1; end
        else         begin e_res_i[i] = dp_res_d[i]; e_ack_i[i] = 1; end
        m_fin[i] = 1;
      end else if (m_k[i] == to_of(i) + 1) begin
        if (m_gr[i]) e_ack_v[i] = 1; else e_ack_i[i] = 1;
        e_err[i] = 1;
        m_fin[i] = 1;
      end else begin
        m_k[i]++;
      end
    end
  endtask

  // One compare process: model advances on the edge, outputs checked 1 time
  // unit later.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) model_step(i);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d.dp_begin", i), W'(o_begin[i]), W'(e_begin[i]));
      chk($sformatf("u%0d.ack_i", i),    W'(o_ack_i[i]), W'(e_ack_i[i]));
      chk($sformatf("u%0d.ack_v", i),    W'(o_ack_v[i]), W'(e_ack_v[i]));
      chk($sformatf("u%0d.err_to", i),   W'(o_err[i]),   W'(e_err[i]));
      chk($sformatf("u%0d.busy", i),     W'(o_busy[i]),  W'(m_act[i] != 0));
      chk($sformatf("u%0d.dp_rst", i),   W'(o_dprst[i]), W'(rst | e_err[i]));
      chk($sformatf("u%0d.dp_operand", i), o_op[i],    e_op[i]);
      chk($sformatf("u%0d.result_i", i),   o_res_i[i], e_res_i[i]);
      chk($sformatf("u%0d.result_v", i),   o_res_v[i], e_res_v[i]);
    end
  end

  // ---------------- driver ----------------
  int           resp_dly[2], cnt[2], n_begin[2], n_ack[2];
  logic [W-1:0] resp_val[2];
  int           more_i[2], more_v[2];
  logic         raise_i[2], raise_v[2];
  logic [0:0]   order_q[$];
  logic [0:0]   exp_q[$];

  // Advance to the next falling edge, then play the chain responder and the
  // two requesters (drop REQ after ACK, optionally re-raise one cycle later).
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      dp_ack_d[i] = 1'b0;
      if (o_begin[i]) begin
        n_begin[i]++;
        cnt[i] = resp_dly[i];
      end else if (cnt[i] > 0) begin
        cnt[i]--;
        if (cnt[i] == 0) begin
          dp_ack_d[i] = 1'b1;
          dp_res_d[i] = resp_val[i];
        end
      end
      if (raise_i[i]) begin req_i_d[i] = 1'b1; raise_i[i] = 1'b0; end
      if (raise_v[i]) begin req_v_d[i] = 1'b1; raise_v[i] = 1'b0; end
      if (o_ack_i[i]) begin
        req_i_d[i] = 1'b0; n_ack[i]++;
        if (i == 0) order_q.push_back(1'b0);
        if (more_i[i] > 0) begin more_i[i]--; raise_i[i] = 1'b1; end
      end
      if (o_ack_v[i]) begin
        req_v_d[i] = 1'b0; n_ack[i]++;
        if (i == 0) order_q.push_back(1'b1);
        if (more_v[i] > 0) begin more_v[i]--; raise_v[i] = 1'b1; end
      end
    end
  endtask

  task automatic wait_begin(input int i, output int ok);
    ok = 0;
    for (int n = 0; n < 50; n++) begin
      step();
      if (o_begin[i]) begin ok = 1; break; end
    end
  endtask

  // Cycles from the Begin cycle to the ACK cycle; -1 if it never comes.
  task automatic wait_ack(input int i, output int lat);
    lat = -1;
    for (int n = 1; n <= 400; n++) begin
      step();
      if (o_ack_i[i] || o_ack_v[i]) begin lat = n; break; end
    end
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int ok, lat, acks_before;
    for (int i = 0; i < 2; i++) begin
      req_i_d[i] = 0; req_v_d[i] = 0; dp_ack_d[i] = 0;
      data_i_d[i] = '0; data_v_d[i] = '0; dp_res_d[i] = '0;
      resp_dly[i] = 0; cnt[i] = 0; n_begin[i] = 0; n_ack[i] = 0;
      resp_val[i] = '0; more_i[i] = 0; more_v[i] = 0;
      raise_i[i] = 0; raise_v[i] = 0;
    end

    // Reset state.
    rst = 1'b1;
    repeat (3) step();
    chk("reset busy", W'(o_busy[0]), '0);
    chk("reset dp_rst", W'(o_dprst[0]), W'(1));
    chk("reset operand", o_op[0], '0);
    chk("reset state", W'(bus0.dbg_state), W'(ST_IDLE));
    rst = 1'b0;
    step();

    // Single request on I, chain answers 10 cycles after Begin.
    resp_dly[0] = 10; resp_val[0] = 32'h402D_F854;
    data_i_d[0] = 32'h0000_4000; req_i_d[0] = 1'b1;
    wait_begin(0, ok);
    chk("t1 begin seen", W'(ok), W'(1));
    chk("t1 operand", o_op[0], 32'h0000_4000);
    wait_ack(0, lat);
    chk("t1 latency", W'(lat), W'(11));
    chk("t1 ack_i", W'(o_ack_i[0]), W'(1));
    chk("t1 result_i", o_res_i[0], 32'h402D_F854);
    chk("t1 result_v", o_res_v[0], '0);
    chk("t1 err_to", W'(o_err[0]), '0);
    chk("t1 single begin", W'(n_begin[0]), W'(1));
    step();

    // Watchdog abort with TIMEOUT=8 on channel V.
    resp_dly[1] = -1;
    data_v_d[1] = 32'h1234_5678; req_v_d[1] = 1'b1;
    wait_begin(1, ok);
    chk("abort begin seen", W'(ok), W'(1));
    wait_ack(1, lat);
    chk("abort latency", W'(lat), W'(10));
    chk("abort ack_v", W'(o_ack_v[1]), W'(1));
    chk("abort err_to", W'(o_err[1]), W'(1));
    chk("abort dp_rst", W'(o_dprst[1]), W'(1));
    chk("abort result_v", o_res_v[1], '0);
    step();
    chk("abort busy after", W'(o_busy[1]), '0);

    // Chain ACK in the very cycle the watchdog would expire.
    resp_dly[1] = 9; resp_val[1] = 32'h3F80_0000;
    data_i_d[1] = 32'h0000_0100; req_i_d[1] = 1'b1;
    wait_begin(1, ok);
    wait_ack(1, lat);
    chk("tie latency", W'(lat), W'(10));
    chk("tie ack_i", W'(o_ack_i[1]), W'(1));
    chk("tie err_to", W'(o_err[1]), '0);
    chk("tie result_i", o_res_i[1], 32'h3F80_0000);
    step();

    // Spurious chain ACK while idle.
    step();
    dp_ack_d[0] = 1'b1; dp_res_d[0] = 32'hDEAD_BEEF;
    step();
    chk("spur ack_i", W'(o_ack_i[0]), '0);
    chk("spur ack_v", W'(o_ack_v[0]), '0);
    chk("spur result_i", o_res_i[0], 32'h402D_F854);
    chk("spur result_v", o_res_v[0], '0);
    step();

    // Reset three cycles into WAIT; the late chain ACK must be ignored.
    resp_dly[0] = 6; resp_val[0] = 32'hAAAA_5555;
    data_i_d[0] = 32'h0000_7000; req_i_d[0] = 1'b1;
    wait_begin(0, ok);
    repeat (3) step();
    acks_before = n_ack[0];
    rst = 1'b1; req_i_d[0] = 1'b0;
    step();
    chk("rst busy", W'(o_busy[0]), '0);
    chk("rst ack_i", W'(o_ack_i[0]), '0);
    chk("rst result_i", o_res_i[0], '0);
    chk("rst operand", o_op[0], '0);
    chk("rst state", W'(bus0.dbg_state), W'(ST_IDLE));
    rst = 1'b0;
    repeat (5) step();
    chk("rst late ack ignored", W'(n_ack[0]), W'(acks_before));
    chk("rst result_i after", o_res_i[0], '0);

    // Both request together and keep requesting: I,V,I,V.
    resp_dly[0] = 3; resp_val[0] = 32'h4120_0000;
    data_i_d[0] = 32'h0000_0111; data_v_d[0] = 32'h0000_0222;
    order_q.delete();
    exp_q = '{1'b0, 1'b1, 1'b0, 1'b1};
    more_i[0] = 1; more_v[0] = 1;
    req_i_d[0] = 1'b1; req_v_d[0] = 1'b1;
    for (int n = 0; n < 200 && order_q.size() < 4; n++) step();
    chk("rr rounds", W'(order_q.size()), W'(4));
    while (exp_q.size() > 0 && order_q.size() > 0) begin
      chk("rr order", W'(order_q.pop_front()), W'(exp_q.pop_front()));
    end
    chk("rr result_v", o_res_v[0], 32'h4120_0000);
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
